// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush scheduler.
//   state_e      scheduler FSM state (run / stalled / flushing)
//   Stall*       stall vector patterns, bit [0]=pc ... [5]=wb, 1 = stop
//   Exc*         exception codes as delivered by MEM
//   redirect_pc  maps an exception code to the redirect address
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    localparam logic [5:0] StallNone = 6'b000000;
    localparam logic [5:0] StallId   = 6'b000111;
    localparam logic [5:0] StallEx   = 6'b001111;
    localparam logic [5:0] StallMem  = 6'b011111;

    localparam logic [31:0] ExcNone        = 32'h0000_0000;
    localparam logic [31:0] ExcInt         = 32'h0000_0001;
    localparam logic [31:0] ExcSyscall     = 32'h0000_0008;
    localparam logic [31:0] ExcInstInvalid = 32'h0000_000a;
    localparam logic [31:0] ExcOverflow    = 32'h0000_000c;
    localparam logic [31:0] ExcTrap        = 32'h0000_000d;
    localparam logic [31:0] ExcEret        = 32'h0000_000e;

    // Interrupts go to their own vector, eret returns to EPC, everything else
    // (including codes we do not recognise) lands on the general exception vector.
    function automatic logic [31:0] redirect_pc(input logic [31:0] code,
                                                input logic [31:0] epc,
                                                input logic [31:0] int_vec,
                                                input logic [31:0] exc_vec);
        logic [31:0] pc;
        case (code)
            ExcInt:  pc = int_vec;
            ExcEret: pc = epc;
            default: pc = exc_vec;
        endcase
        return pc;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Control bundle between the pipeline stages and the stall/flush scheduler.
//   stallreq_from_id/ex/mem  stall requests from ID, EX, MEM
//   excepttype_i             final exception code from MEM, 0 = none
//   cp0_epc_i                EPC from CP0, target for eret
//   stall                    6-bit stage freeze vector
//   flush                    flush all pipeline registers this cycle
//   new_pc                   redirect address, valid while flush=1
// master = pipeline side, slave = scheduler.
interface pipe_ctrl_if;

    logic        stallreq_from_id;
    logic        stallreq_from_ex;
    logic        stallreq_from_mem;
    logic [31:0] excepttype_i;
    logic [31:0] cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;

    modport master (
        output stallreq_from_id,
        output stallreq_from_ex,
        output stallreq_from_mem,
        output excepttype_i,
        output cp0_epc_i,
        input  stall,
        input  flush,
        input  new_pc
    );

    modport slave (
        input  stallreq_from_id,
        input  stallreq_from_ex,
        input  stallreq_from_mem,
        input  excepttype_i,
        input  cp0_epc_i,
        output stall,
        output flush,
        output new_pc
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk   clock
//   rst   synchronous active-high reset, clears the count
//   inc   count up by one (holds at all-ones)
//   clr   clear to zero, wins over inc
//   cnt   current count
module pipe_ctrl_sat_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush scheduler for the 5-stage core. Merges ID/EX/MEM stall
// requests into the stage freeze vector, sequences an exception flush with its
// redirect PC, and keeps stall statistics plus a sticky stall watchdog.
//   clk              core clock
//   rst              synchronous reset, active-high
//   ctrl             slave side of pipe_ctrl_if (requests in, stall/flush/new_pc out)
//   stall_cnt_o      total cycles with a non-zero stall vector, saturating
//   stall_timeout_o  sticky: a consecutive stall run reached STALL_LIMIT
import pipe_ctrl_pkg::*;

module pipe_ctrl #(
    parameter logic [31:0] INT_VECTOR  = 32'h0000_0020,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0040,
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    pipe_ctrl_if.slave       ctrl,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             stall_timeout_o
);

    // Run counter only has to reach STALL_LIMIT; it saturates above that.
    localparam int unsigned    RunW    = $clog2(STALL_LIMIT + 1);
    localparam logic [RunW-1:0] RunTrip = RunW'(STALL_LIMIT - 1);

    state_e state_q, state_d;

    logic [5:0]      stall_vec;
    logic            flush_now;
    logic [31:0]     redirect;
    logic            stall_any;
    logic [RunW-1:0] run_cnt;
    logic            timeout_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: any accepted exception spends exactly one cycle in FLUSH.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StFlush: state_d = StRun;
            default: begin
                if (flush_now) begin
                    state_d = StFlush;
                end else if (stall_any) begin
                    state_d = StStall;
                end else begin
                    state_d = StRun;
                end
            end
        endcase
    end

    // Outputs: combinational from inputs and state. In FLUSH every request and
    // exception is ignored so the bubbles just injected move down the pipe.
    always_comb begin
        stall_vec = StallNone;
        flush_now = 1'b0;
        redirect  = '0;
        if (!rst && (state_q != StFlush)) begin
            if (ctrl.excepttype_i != ExcNone) begin
                flush_now = 1'b1;
                redirect  = redirect_pc(ctrl.excepttype_i, ctrl.cp0_epc_i,
                                        INT_VECTOR, EXC_VECTOR);
            end else if (ctrl.stallreq_from_mem) begin
                stall_vec = StallMem;
            end else if (ctrl.stallreq_from_ex) begin
                stall_vec = StallEx;
            end else if (ctrl.stallreq_from_id) begin
                stall_vec = StallId;
            end
        end
    end

    assign stall_any   = (stall_vec != StallNone);
    assign ctrl.stall  = stall_vec;
    assign ctrl.flush  = flush_now;
    assign ctrl.new_pc = redirect;

    pipe_ctrl_sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(stall_any),
        .clr(1'b0),
        .cnt(stall_cnt_o)
    );

    pipe_ctrl_sat_counter #(
        .WIDTH(RunW)
    ) u_run_cnt (
        .clk(clk),
        .rst(rst),
        .inc(stall_any),
        .clr(!stall_any || flush_now),
        .cnt(run_cnt)
    );

    // Trip on the edge where the run counter becomes STALL_LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (stall_any && (run_cnt == RunTrip)) begin
            timeout_q <= 1'b1;
        end
    end

    assign stall_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int unsigned Limit = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus ();
    pipe_ctrl_if bus_s ();

    assign bus_s.stallreq_from_id  = bus.stallreq_from_id;
    assign bus_s.stallreq_from_ex  = bus.stallreq_from_ex;
    assign bus_s.stallreq_from_mem = bus.stallreq_from_mem;
    assign bus_s.excepttype_i      = bus.excepttype_i;
    assign bus_s.cp0_epc_i         = bus.cp0_epc_i;

    logic [31:0] cnt;
    logic        to;
    logic [2:0]  cnt_s;
    logic        to_s;

    pipe_ctrl #(
        .INT_VECTOR (32'h0000_0020),
        .EXC_VECTOR (32'h0000_0040),
        .STALL_LIMIT(Limit),
        .CNT_W      (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl           (bus),
        .stall_cnt_o    (cnt),
        .stall_timeout_o(to)
    );

    // Narrow statistics counter to exercise saturation.
    pipe_ctrl #(
        .INT_VECTOR (32'h0000_0020),
        .EXC_VECTOR (32'h0000_0040),
        .STALL_LIMIT(Limit),
        .CNT_W      (3)
    ) dut_s (
        .clk            (clk),
        .rst            (rst),
        .ctrl           (bus_s),
        .stall_cnt_o    (cnt_s),
        .stall_timeout_o(to_s)
    );

    typedef struct packed {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] cnt;
        logic [2:0]  cnt_s;
        logic        to;
    } exp_t;

    exp_t sb[$];

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Reference model state
    bit          m_flush = 1'b0;
    int unsigned m_cnt   = 0;
    int unsigned m_cnt_s = 0;
    int unsigned m_run   = 0;
    bit          m_to    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle just after posedge, check at negedge, advance model at next posedge.
    task automatic step(input logic r, input logic id, input logic ex, input logic mem,
                        input logic [31:0] exc, input logic [31:0] epc);
        exp_t e;
        exp_t o;
        rst                   = r;
        bus.stallreq_from_id  = id;
        bus.stallreq_from_ex  = ex;
        bus.stallreq_from_mem = mem;
        bus.excepttype_i      = exc;
        bus.cp0_epc_i         = epc;

        e = '0;
        if (!r && !m_flush) begin
            if (exc != 32'h0) begin
                e.flush = 1'b1;
                if (exc == 32'h1)      e.pc = 32'h0000_0020;
                else if (exc == 32'he) e.pc = epc;
                else                   e.pc = 32'h0000_0040;
            end else if (mem) e.stall = 6'b011111;
            else if (ex)      e.stall = 6'b001111;
            else if (id)      e.stall = 6'b000111;
        end
        e.cnt   = m_cnt;
        e.cnt_s = m_cnt_s[2:0];
        e.to    = m_to;
        sb.push_back(e);

        @(negedge clk);
        o = sb.pop_front();
        check("stall",   {26'b0, bus.stall}, {26'b0, o.stall});
        check("flush",   {31'b0, bus.flush}, {31'b0, o.flush});
        check("new_pc",  bus.new_pc,         o.pc);
        check("cnt",     cnt,                o.cnt);
        check("cnt_sat", {29'b0, cnt_s},     {29'b0, o.cnt_s});
        check("timeout", {31'b0, to},        {31'b0, o.to});
        check("timeout_s", {31'b0, to_s},    {31'b0, o.to});

        @(posedge clk);
        #1;
        if (r) begin
            m_flush = 1'b0;
            m_cnt   = 0;
            m_cnt_s = 0;
            m_run   = 0;
            m_to    = 1'b0;
        end else begin
            m_flush = e.flush;
            if (e.stall != 6'b0) begin
                if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                if (m_cnt_s < 7) m_cnt_s++;
                m_run++;
                if (m_run >= Limit) m_to = 1'b1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    initial begin
        rst                   = 1'b1;
        bus.stallreq_from_id  = 1'b1;
        bus.stallreq_from_ex  = 1'b1;
        bus.stallreq_from_mem = 1'b1;
        bus.excepttype_i      = 32'h1;
        bus.cp0_epc_i         = 32'h0;
        @(posedge clk);
        #1;

        // Reset dominates all requests
        step(1, 1, 1, 1, 32'h1, 32'h0);
        step(1, 1, 1, 1, 32'h1, 32'h0);

        // Single ID request then idle
        step(0, 1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Priority merge, drop MEM
        step(0, 1, 1, 1, 32'h0, 32'h0);
        step(0, 1, 1, 0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Interrupt with EX req, held syscall dropped in FLUSH, then taken
        step(0, 0, 1, 0, 32'h1, 32'h0);
        step(0, 0, 1, 0, 32'h8, 32'h0);
        step(0, 0, 0, 0, 32'h8, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // eret and the other codes
        step(0, 0, 0, 0, 32'he, 32'hBFC0_0100);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 1, 1, 32'ha, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'hd, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'hc, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h3, 32'hDEAD_BEEF);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Watchdog: runs of 3 broken by a gap or a flush do not trip
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h8, 32'h0);
        step(0, 0, 0, 1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Four consecutive stalls trip it; it stays set
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        // Reset clears everything again
        step(1, 0, 1, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
